// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: default widths, opcode encoding and FSM states.
package exec_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;
    localparam int OPW    = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'd0;
    localparam logic [OPW-1:0] OP_ADD = 4'd1;
    localparam logic [OPW-1:0] OP_SUB = 4'd2;
    localparam logic [OPW-1:0] OP_AND = 4'd3;
    localparam logic [OPW-1:0] OP_OR  = 4'd4;
    localparam logic [OPW-1:0] OP_XOR = 4'd5;
    localparam logic [OPW-1:0] OP_SHL = 4'd6;
    localparam logic [OPW-1:0] OP_SHR = 4'd7;
    localparam logic [OPW-1:0] OP_MOV = 4'd8;
    localparam logic [OPW-1:0] OP_MUL = 4'd9;
    localparam logic [OPW-1:0] OP_CMP = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/exec_stage_mul.sv
// Serial shift-add multiplier: one multiplier bit per clock, W clocks per product.
module mul_serial #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;
    logic           busy;

    // mcand is shifted left each step, so it always equals multiplicand << count.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        done     = busy && (count == CW'(W - 1));
        product  = acc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{W{1'b0}}, multiplicand};
            acc    <= '0;
            mplier <= multiplier;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus serial MUL, driving the register file write port.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op,
    input  logic [AW-1:0]  dst,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [DW-1:0]  imm,
    input  logic           use_imm,
    output logic           wb_we,
    output logic [AW-1:0]  wb_dst,
    output logic [DW-1:0]  wb_data,
    output logic           flag_z,
    output logic           flag_c
);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [2*DW-1:0] mul_product;
    logic [AW-1:0]   mul_dst;
    logic [DW-1:0]   b_op;
    logic [DW:0]     sum;
    logic [DW:0]     diff;
    logic [DW-1:0]   alu_res;
    logic            alu_c;
    logic            alu_we;
    logic            alu_flags;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign b_op      = use_imm ? imm : b;
    assign sum       = {1'b0, a} + {1'b0, b_op};
    assign diff      = {1'b0, a} - {1'b0, b_op};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The top bit of the DW+1-bit difference is the borrow.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_we    = 1'b0;
        alu_flags = 1'b0;
        case (op)
            OP_ADD: begin alu_res = sum[DW-1:0];  alu_c = sum[DW];  alu_we = 1'b1; alu_flags = 1'b1; end
            OP_SUB: begin alu_res = diff[DW-1:0]; alu_c = diff[DW]; alu_we = 1'b1; alu_flags = 1'b1; end
            OP_AND: begin alu_res = a & b_op; alu_we = 1'b1; alu_flags = 1'b1; end
            OP_OR:  begin alu_res = a | b_op; alu_we = 1'b1; alu_flags = 1'b1; end
            OP_XOR: begin alu_res = a ^ b_op; alu_we = 1'b1; alu_flags = 1'b1; end
            OP_SHL: begin alu_res = {a[DW-2:0], 1'b0}; alu_c = a[DW-1]; alu_we = 1'b1; alu_flags = 1'b1; end
            OP_SHR: begin alu_res = {1'b0, a[DW-1:1]}; alu_c = a[0];    alu_we = 1'b1; alu_flags = 1'b1; end
            OP_MOV: begin alu_res = b_op; alu_we = 1'b1; end
            OP_CMP: begin alu_res = diff[DW-1:0]; alu_c = diff[DW]; alu_flags = 1'b1; end
            default: ;
        endcase
    end

    mul_serial #(.W(DW)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (a),
        .multiplier   (b_op),
        .done         (mul_done),
        .product      (mul_product)
    );

    // A MUL finishes only while in_ready is low, so it never collides with an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_dst  <= '0;
            wb_data <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            mul_dst <= '0;
        end else begin
            wb_we <= 1'b0;
            if (mul_start) begin
                mul_dst <= dst;
            end
            if (accept && alu_we) begin
                wb_we   <= 1'b1;
                wb_dst  <= dst;
                wb_data <= alu_res;
            end
            if (accept && alu_flags) begin
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
            end
            if (mul_done) begin
                wb_we   <= 1'b1;
                wb_dst  <= mul_dst;
                wb_data <= mul_product[DW-1:0];
                flag_z  <= (mul_product[DW-1:0] == '0);
                flag_c  <= (mul_product[2*DW-1:DW] != '0);
            end
        end
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
Execute stage of the 8-bit RISC-like CPU, sitting directly downstream of the 16x8 register file.
- Consumes the two read-port operands (data0/data1) plus decoded opcode, destination and immediate.
- Computes the ALU result and holds Z/C flags.
- Drives the register file write port (we/dst/data) from registered outputs.
- Most ops take one cycle. MUL is serial and multi-cycle, so the stage backpressures the decode stage through a valid/ready handshake.

Parameters:
DW, 8, datapath width; must match register file data width
AW, 4, register address width; must match register file address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  decode presents an instruction this cycle
in_ready  output  1  stage can accept; equals (state==IDLE), combinational from state only
op  input  4  opcode, encoding per exec_pkg
dst  input  AW  destination register index
a  input  DW  operand A (register file data0)
b  input  DW  operand B (register file data1)
imm  input  DW  immediate
use_imm  input  1  1: imm replaces b as operand B
wb_we  output  1  register file write enable, one-cycle pulse
wb_dst  output  AW  register file write address
wb_data  output  DW  register file write data
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag

Behaviour:
- Reset: state IDLE, in_ready=1, wb_we=0, wb_dst=0, wb_data=0, flag_z=0, flag_c=0, multiplier state cleared.
- Accept: an instruction is taken on a rising edge where in_valid && in_ready. Operand B is imm if use_imm, else b. Operands are captured at that edge.
- Opcodes (op):
  - 0 NOP: no write, no flags.
  - 1 ADD: C = carry out.
  - 2 SUB: a-B, C = borrow (a<B unsigned).
  - 3 AND, 4 OR, 5 XOR: C=0.
  - 6 SHL by 1: C=a[DW-1].
  - 7 SHR logical by 1: C=a[0].
  - 8 MOV: result=B; no flag update.
  - 9 MUL: result = low DW bits of a*B; C = (high DW bits != 0).
  - 10 CMP: SUB flags only, wb_we=0.
  - 11-15: treated as NOP.
- Flags: Z = (DW-bit result == 0) for ops 1-7, 9 and 10. Flags change only at the edge that produces the result and hold otherwise.
- Single-cycle ops (1-8):
  - Accepted at edge N: wb_we/wb_dst/wb_data/flags valid during the cycle after edge N.
  - wb_we is high for exactly one cycle.
  - Back-to-back accepts give wb_we high on consecutive cycles.
- NOP/CMP/illegal: wb_we=0 in the cycle after accept; wb_dst/wb_data keep their previous values.
- MUL FSM, states IDLE and MUL:
  - Accept at edge N: go IDLE->MUL, load multiplicand, multiplier and a 2*DW accumulator, count=0.
  - Each edge in MUL: if multiplier LSB, add multiplicand<<count into the accumulator; shift the multiplier right; count++.
  - At edge N+DW (count==DW-1 processed): go MUL->IDLE, register result and flags, wb_we=1. Total latency DW edges.
  - in_ready=0 from after edge N until the cycle after edge N+DW. An instruction held on in_valid during MUL is not consumed.
  - In the writeback cycle in_ready=1, so a new accept may coincide with the MUL wb_we pulse.
- wb_we is never asserted in consecutive cycles for the same instruction.
- Reset mid-MUL: abandon; no write pulse; state IDLE and flags cleared on the next cycle.
- No forwarding or hazard detection: the register file write lands at the edge ending the wb_we cycle, and decode is responsible for RAW spacing.
- Arithmetic is unsigned and modulo 2^DW. Carry and borrow use a DW+1-bit intermediate.

Decomposition:
- exec_pkg: DW/AW defaults, opcode constants OP_NOP..OP_CMP, FSM state encoding.
- Sub-module mul_serial (shift-add, start/done, DW-cycle, 2*DW product).
- The ALU case statement stays inline in exec_stage.

Test Plan:
- ADD a=0xF0 b=0x20 dst=3 -> next cycle wb_we=1, wb_dst=3, wb_data=0x10, C=1, Z=0; following cycle wb_we=0.
- SUB a=0x05, use_imm=1 imm=0x05, dst=7 -> wb_data=0x00, Z=1, C=0. Then CMP a=0x03 b=0x07 -> wb_we=0, C=1, Z=0, wb_data still 0x00.
- MUL a=13 b=21 dst=2, in_valid held with an ADD behind it -> in_ready=0 for 8 cycles, then wb_data=0x11, C=1, Z=0; the ADD is accepted in the writeback cycle and its wb_we follows the next cycle.
- Back-to-back stream XOR 0xAA^0xAA, MOV b=0x5C, SHL a=0x81 -> consecutive wb pulses with data 0x00 (Z=1), 0x5C (flags unchanged: Z=1, C=0), 0x02 (C=1, Z=0).
- rst_n=0 asserted 4 cycles into MUL -> no wb_we pulse ever, in_ready=1 and flag_z=flag_c=0 the next cycle, wb_data=0.
- Opcodes 0 and 11-15 with in_valid -> accepted, in_ready stays 1, wb_we never asserted, flags unchanged.
